alu_nibble_sequencer: RTL and testbench

- Multi-precision controller for the 4-bit registered arithmetic unit (registered inputs a, b, ~b, s0, s1, cin; registered outputs d and cout).
- Accepts a WORDS-nibble operation with a start/busy/done handshake.
- Issues one nibble at a time, least significant first, to the shared 4-bit unit and chains each nibble's carry-out into the next nibble's carry-in.
- Sits between the requesting control logic and the 4-bit arithmetic unit instance.

---
 rtl/alu_nibble_sequencer_if.sv | 38 +++
 rtl/alu_nibble_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/alu_nibble_sequencer_if.sv
// Bus bundle for alu_nibble_sequencer.
// Groups the requester handshake (start/op/opa/opb -> busy/done/result/
// cout_o/zero_o) and the link to the shared 4-bit arithmetic unit
// (alu_a/alu_b/alu_s0/alu_s1/alu_cin -> alu_d/alu_cout).
//   slave  : the sequencer side.
//   master : the environment side (requester plus the arithmetic unit).
interface alu_nibble_sequencer_if #(
  parameter int WORDS = 4
);
  logic                 start;
  logic [2:0]           op;
  logic [4*WORDS-1:0]   opa;
  logic [4*WORDS-1:0]   opb;
  logic                 busy;
  logic                 done;
  logic [4*WORDS-1:0]   result;
  logic                 cout_o;
  logic                 zero_o;
  logic [3:0]           alu_a;
  logic [3:0]           alu_b;
  logic                 alu_s0;
  logic                 alu_s1;
  logic                 alu_cin;
  logic [3:0]           alu_d;
  logic                 alu_cout;

  modport slave (
    input  start, op, opa, opb, alu_d, alu_cout,
    output busy, done, result, cout_o, zero_o,
           alu_a, alu_b, alu_s0, alu_s1, alu_cin
  );

  modport master (
    output start, op, opa, opb, alu_d, alu_cout,
    input  busy, done, result, cout_o, zero_o,
           alu_a, alu_b, alu_s0, alu_s1, alu_cin
  );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer
// Runs a 4*WORDS-bit add/subtract/increment/decrement through a shared
// registered 4-bit arithmetic unit, one nibble at a time (LSB first),
// chaining each nibble's carry-out into the next nibble's carry-in.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - alu_nibble_sequencer_if.slave: start/op/opa/opb request,
//          busy/done/result/cout_o/zero_o status, alu_* link to the unit
// Every output is a register; the next value of each register is built in
// one combinational block and loaded in one clocked block.
module alu_nibble_sequencer #(
  parameter int WORDS   = 4,
  parameter int ALU_LAT = 2
) (
  input logic                   clk,
  input logic                   rst,
  alu_nibble_sequencer_if.slave bus
);

  localparam int W     = 4 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ALU_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t             r_state,  w_stateNext;
  logic [W-1:0]       r_opa,    w_opaNext;
  logic [W-1:0]       r_opb,    w_opbNext;
  logic [1:0]         r_sel,    w_selNext;
  logic [IDX_W-1:0]   r_idx,    w_idxNext;
  logic [CNT_W-1:0]   r_cnt,    w_cntNext;
  logic               r_carry,  w_carryNext;
  logic [W-1:0]       r_shadow, w_shadowNext;
  logic [W-1:0]       r_result, w_resultNext;
  logic               r_cout,   w_coutNext;
  logic               r_zero,   w_zeroNext;
  logic               r_busy,   w_busyNext;
  logic               r_done,   w_doneNext;
  logic [3:0]         r_aluA,   w_aluANext;
  logic [3:0]         r_aluB,   w_aluBNext;
  logic               r_aluS0,  w_aluS0Next;
  logic               r_aluS1,  w_aluS1Next;
  logic               r_aluCin, w_aluCinNext;

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_opa    <= '0;
      r_opb    <= '0;
      r_sel    <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_shadow <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_aluA   <= '0;
      r_aluB   <= '0;
      r_aluS0  <= 1'b0;
      r_aluS1  <= 1'b0;
      r_aluCin <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_opa    <= w_opaNext;
      r_opb    <= w_opbNext;
      r_sel    <= w_selNext;
      r_idx    <= w_idxNext;
      r_cnt    <= w_cntNext;
      r_carry  <= w_carryNext;
      r_shadow <= w_shadowNext;
      r_result <= w_resultNext;
      r_cout   <= w_coutNext;
      r_zero   <= w_zeroNext;
      r_busy   <= w_busyNext;
      r_done   <= w_doneNext;
      r_aluA   <= w_aluANext;
      r_aluB   <= w_aluBNext;
      r_aluS0  <= w_aluS0Next;
      r_aluS1  <= w_aluS1Next;
      r_aluCin <= w_aluCinNext;
    end
  end

  // Next-state and next-output logic. The alu_* registers are loaded on the
  // edge entering ISSUE from the already-updated operand/index/carry values,
  // so the unit sees a stable nibble for the whole ISSUE cycle and samples
  // it on the edge leaving ISSUE; they then hold through WAIT.
  always_comb begin
    w_stateNext  = r_state;
    w_opaNext    = r_opa;
    w_opbNext    = r_opb;
    w_selNext    = r_sel;
    w_idxNext    = r_idx;
    w_cntNext    = r_cnt;
    w_carryNext  = r_carry;
    w_shadowNext = r_shadow;
    w_resultNext = r_result;
    w_coutNext   = r_cout;
    w_zeroNext   = r_zero;
    w_busyNext   = 1'b0;
    w_doneNext   = 1'b0;
    w_aluANext   = '0;
    w_aluBNext   = '0;
    w_aluS0Next  = 1'b0;
    w_aluS1Next  = 1'b0;
    w_aluCinNext = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_opaNext   = bus.opa;
          w_opbNext   = bus.opb;
          w_selNext   = bus.op[2:1];
          w_idxNext   = '0;
          w_carryNext = bus.op[0];
          w_stateNext = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cntNext   = '0;
        w_stateNext = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == LAST_CNT) begin
          w_shadowNext[{r_idx, 2'b00} +: 4] = bus.alu_d;
          w_carryNext = bus.alu_cout;
          if (r_idx == LAST_IDX) begin
            w_resultNext = w_shadowNext;
            w_coutNext   = bus.alu_cout;
            w_zeroNext   = (w_shadowNext == '0);
            w_stateNext  = S_DONE;
          end else begin
            w_idxNext   = r_idx + 1'b1;
            w_stateNext = S_ISSUE;
          end
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase

    w_busyNext = (w_stateNext == S_ISSUE) || (w_stateNext == S_WAIT);
    w_doneNext = (w_stateNext == S_DONE);

    if (w_stateNext == S_ISSUE) begin
      w_aluANext   = w_opaNext[{w_idxNext, 2'b00} +: 4];
      w_aluBNext   = w_opbNext[{w_idxNext, 2'b00} +: 4];
      w_aluS0Next  = w_selNext[1];
      w_aluS1Next  = w_selNext[0];
      w_aluCinNext = w_carryNext;
    end else if (w_stateNext == S_WAIT) begin
      w_aluANext   = r_aluA;
      w_aluBNext   = r_aluB;
      w_aluS0Next  = r_aluS0;
      w_aluS1Next  = r_aluS1;
      w_aluCinNext = r_aluCin;
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.result  = r_result;
  assign bus.cout_o  = r_cout;
  assign bus.zero_o  = r_zero;
  assign bus.alu_a   = r_aluA;
  assign bus.alu_b   = r_aluB;
  assign bus.alu_s0  = r_aluS0;
  assign bus.alu_s1  = r_aluS1;
  assign bus.alu_cin = r_aluCin;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Testbench for alu_nibble_sequencer.
// Provides a model of the registered 4-bit arithmetic unit (input register
// stage plus output register stage), drives directed and random operations,
// and checks completed results against a full-width arithmetic reference
// through a scoreboard queue popped by an independent done monitor.
module tb_alu_nibble_sequencer;

  localparam int WORDS   = 4;
  localparam int ALU_LAT = 2;
  localparam int W       = 4 * WORDS;
  localparam int STEP    = 1 + ALU_LAT;
  localparam int LAT     = WORDS * STEP;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  exp_t monE;

  alu_nibble_sequencer_if #(.WORDS(WORDS)) bus ();

  alu_nibble_sequencer #(.WORDS(WORDS), .ALU_LAT(ALU_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model of the shared arithmetic unit: inputs captured on one edge,
  // d/cout produced from the captured inputs on the following edge.
  logic [3:0] aluAQ, aluBQ, aluDQ;
  logic       aluS0Q, aluS1Q, aluCinQ, aluCoutQ;
  logic [3:0] aluYw;

  assign aluYw = aluS0Q ? (aluS1Q ? 4'hF : 4'h0) : (aluS1Q ? ~aluBQ : aluBQ);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aluAQ <= '0; aluBQ <= '0; aluS0Q <= 1'b0; aluS1Q <= 1'b0; aluCinQ <= 1'b0;
      aluDQ <= '0; aluCoutQ <= 1'b0;
    end else begin
      aluAQ   <= bus.alu_a;
      aluBQ   <= bus.alu_b;
      aluS0Q  <= bus.alu_s0;
      aluS1Q  <= bus.alu_s1;
      aluCinQ <= bus.alu_cin;
      {aluCoutQ, aluDQ} <= {1'b0, aluAQ} + {1'b0, aluYw} + {4'b0, aluCinQ};
    end
  end

  assign bus.alu_d    = aluDQ;
  assign bus.alu_cout = aluCoutQ;

  // Full-width second operand selected by {s0,s1}.
  function automatic logic [W-1:0] refY(input logic [W-1:0] b, input logic [2:0] op);
    if (op[2]) return op[1] ? {W{1'b1}} : {W{1'b0}};
    return op[1] ? ~b : b;
  endfunction

  function automatic logic [W:0] refSum(input logic [W-1:0] a, b, input logic [2:0] op);
    return {1'b0, a} + {1'b0, refY(b, op)} + {{W{1'b0}}, op[0]};
  endfunction

  // Carry entering nibble k of the full-width sum.
  function automatic logic refCin(input logic [W-1:0] a, b, input logic [2:0] op, input int k);
    logic [31:0] mask, low;
    if (k == 0) return op[0];
    mask = (32'd1 << (4 * k)) - 32'd1;
    low  = (32'(a) & mask) + (32'(refY(b, op)) & mask) + 32'(op[0]);
    return low[4 * k];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        monE = sbq.pop_front();
        checkOutput("result", 32'(bus.result), 32'(monE.res));
        checkOutput("cout_o", 32'(bus.cout_o), 32'(monE.cout));
        checkOutput("zero_o", 32'(bus.zero_o), 32'(monE.res == '0));
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"},   32'(bus.busy),   32'd0);
    checkOutput({tag, "_done"},   32'(bus.done),   32'd0);
    checkOutput({tag, "_result"}, 32'(bus.result), 32'd0);
    checkOutput({tag, "_cout"},   32'(bus.cout_o), 32'd0);
    checkOutput({tag, "_zero"},   32'(bus.zero_o), 32'd1);
    checkOutput({tag, "_alu"},    32'({bus.alu_a, bus.alu_b, bus.alu_s0, bus.alu_s1, bus.alu_cin}), 32'd0);
  endtask

  // Issue one operation, track busy/latency, check each ISSUE nibble.
  // poke re-asserts start and scrambles operands mid-operation;
  // abortAt >= 0 applies reset in that cycle.
  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, b,
                               input bit poke, input int abortAt);
    logic [W:0] full;
    exp_t e;
    int c, busyCnt, doneAt, nib, doneSeen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.opa = a; bus.opb = b;
    full = refSum(a, b, op);
    e.res = full[W-1:0]; e.cout = full[W];
    sbq.push_back(e);
    @(posedge clk);
    c = 0; busyCnt = 0; doneAt = -1;
    while (c < LAT + 20) begin
      @(negedge clk);
      bus.start = poke && (c == 3 || c == 8);
      if (poke && c == 3) begin
        bus.opa = W'($urandom); bus.opb = ~bus.opb; bus.op = 3'(~op);
      end
      if (bus.busy) busyCnt++;
      if ((c % STEP) == 0 && c < LAT) begin
        nib = c / STEP;
        checkOutput("alu_cin", 32'(bus.alu_cin), 32'(refCin(a, b, op, nib)));
        checkOutput("alu_a", 32'(bus.alu_a), 32'(a[4*nib +: 4]));
      end
      if (c == abortAt) begin
        void'(sbq.pop_back());
        #1 rst = 1'b1;
        #1 checkResetOutputs("abort");
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 0;
        repeat (LAT + 4) begin
          @(negedge clk);
          if (bus.done) doneSeen++;
        end
        checkOutput("aborted_done_count", 32'(doneSeen), 32'd0);
        return;
      end
      if (bus.done) begin
        doneAt = c;
        break;
      end
      @(posedge clk);
      c++;
    end
    bus.start = 1'b0;
    if (doneAt < 0) begin
      checkOutput("done_timeout", 32'd1, 32'd0);
    end else begin
      checkOutput("latency", 32'(doneAt), 32'(LAT));
      checkOutput("busy_cycles", 32'(busyCnt), 32'(LAT));
      @(negedge clk);
      checkOutput("done_width", 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.opa = '0; bus.opb = '0;
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(3'b000, 16'h1234, 16'h0FFF, 1'b0, -1);
    applyStimulus(3'b011, 16'h1000, 16'h0001, 1'b0, -1);
    applyStimulus(3'b011, 16'h0000, 16'h0001, 1'b0, -1);
    applyStimulus(3'b101, 16'hFFFF, 16'h1357, 1'b0, -1);
    applyStimulus(3'b110, 16'h0000, 16'h2468, 1'b0, -1);
    applyStimulus(3'b100, 16'hA5A5, 16'h5A5A, 1'b0, -1);
    applyStimulus(3'b000, 16'h4321, 16'h1111, 1'b1, -1);
    applyStimulus(3'b000, 16'h7777, 16'h8888, 1'b0, 5);
    applyStimulus(3'b001, 16'h0001, 16'h0001, 1'b0, -1);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'b0, -1);
    end

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
